byte_pair_loader: RTL and testbench



---
 rtl/byte_pair_loader.sv | 118 +++++++++++
 tb/tb_byte_pair_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_pair_loader.sv
// Byte-pair loader: steers a byte stream into the high/low halves of a split-half load register.
// Optional partial-word timeout is enabled by defining PARTIAL_TIMEOUT_EN.
module byte_pair_loader #(
    parameter int N        = 16,
    parameter int HI_FIRST = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N/2-1:0]   byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [N/2-1:0]   inh,
    output logic [N/2-1:0]   inl,
    output logic             loadh,
    output logic             loadl,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [7:0]       word_count,
    output logic             timeout
);

    // Handshake: a byte transfers on any cycle where byte_valid and byte_ready are both high.
    localparam logic [1:0] S_FIRST  = 2'd0;
    localparam logic [1:0] S_SECOND = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] word_count_q, word_count_d;
    logic       hs;
    logic       first_slot;
    logic       second_slot;

`ifdef PARTIAL_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    assign inh        = byte_in;
    assign inl        = byte_in;
    assign word_valid = (state_q == S_FULL);
    assign word_count = word_count_q;

    always_comb begin
        byte_ready   = !clear && ((state_q != S_FULL) || word_ready);
        hs           = byte_valid && byte_ready;
        // In S_FULL a handshake only happens while the old word is consumed, so it starts a new pair.
        first_slot   = hs && ((state_q == S_FIRST) || (state_q == S_FULL));
        second_slot  = hs && (state_q == S_SECOND);
        loadh        = (HI_FIRST != 0) ? first_slot : second_slot;
        loadl        = (HI_FIRST != 0) ? second_slot : first_slot;
        state_d      = state_q;
        word_count_d = word_count_q;
`ifdef PARTIAL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            S_FIRST: begin
                if (hs) begin
                    state_d = S_SECOND;
`ifdef PARTIAL_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end
            end
            S_SECOND: begin
                if (hs) begin
                    state_d      = S_FULL;
                    word_count_d = word_count_q + 8'd1;
                end
`ifdef PARTIAL_TIMEOUT_EN
                else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = S_FIRST;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            S_FULL: begin
                if (word_ready) begin
                    state_d = hs ? S_SECOND : S_FIRST;
`ifdef PARTIAL_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= S_FIRST;
            word_count_q <= 8'd0;
`ifdef PARTIAL_TIMEOUT_EN
            tmo_cnt_q    <= 8'd0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
`ifdef PARTIAL_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

`ifdef PARTIAL_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // No timeout logic: the port is tied low (the term is false for every legal TIMEOUT).
    assign timeout = (TIMEOUT < 1);
`endif

endmodule

// File: tb/tb_byte_pair_loader.sv
// Bench for byte_pair_loader: two instances (HI_FIRST=1 and HI_FIRST=0) share one stimulus stream
// and are checked every cycle against a pair-level reference model with a queue of expected words.
module tb_byte_pair_loader;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       word_ready = 1'b0;

    logic       byte_ready, loadh, loadl, word_valid, timeout;
    logic [7:0] inh, inl, word_count;
    logic       byte_ready_b, loadh_b, loadl_b, word_valid_b, timeout_b;
    logic [7:0] inh_b, inl_b, word_count_b;

    logic [15:0] r_hi = 16'h0;
    logic [15:0] r_lo = 16'h0;

    int checks = 0;
    int errors = 0;

    // Reference model state, in terms of pair progress rather than FSM encoding
    bit          m_full = 0;
    int          m_have = 0;
    logic [7:0]  m_first = 8'h0;
    logic [7:0]  m_count = 8'h0;
    int          m_idle = 0;
    bit          m_tmo = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    byte_pair_loader #(.N(16), .HI_FIRST(1), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .clear(clear), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .inh(inh), .inl(inl), .loadh(loadh), .loadl(loadl),
        .word_valid(word_valid), .word_ready(word_ready), .word_count(word_count),
        .timeout(timeout)
    );

    byte_pair_loader #(.N(16), .HI_FIRST(0), .TIMEOUT(TMO)) u_dut_lo (
        .clk(clk), .clear(clear), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_b), .inh(inh_b), .inl(inl_b), .loadh(loadh_b), .loadl(loadl_b),
        .word_valid(word_valid_b), .word_ready(word_ready), .word_count(word_count_b),
        .timeout(timeout_b)
    );

    // Downstream split-half registers, sharing clear
    always @(posedge clk) begin
        if (clear) begin
            r_hi <= 16'h0;
            r_lo <= 16'h0;
        end else begin
            if (loadh)   r_hi[15:8] <= inh;
            if (loadl)   r_hi[7:0]  <= inl;
            if (loadh_b) r_lo[15:8] <= inh_b;
            if (loadl_b) r_lo[7:0]  <= inl_b;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] b, input bit wr, input bit clr);
        bit exp_ready, hs, first, second;
        byte_valid = v;
        byte_in    = b;
        word_ready = wr;
        clear      = clr;
        #2;
        exp_ready = !clr && (!m_full || wr);
        hs        = v && exp_ready;
        first     = hs && (m_full || m_have == 0);
        second    = hs && !m_full && m_have == 1;
        check("byte_ready", 16'(byte_ready), 16'(exp_ready));
        check("loadh", 16'(loadh), 16'(first));
        check("loadl", 16'(loadl), 16'(second));
        check("lo_loadh", 16'(loadh_b), 16'(second));
        check("lo_loadl", 16'(loadl_b), 16'(first));
        check("inh", 16'(inh), 16'(b));
        check("inl_lo", 16'(inl_b), 16'(b));
        check("word_valid", 16'(word_valid), 16'(m_full));
        check("lo_word_valid", 16'(word_valid_b), 16'(m_full));
        check("word_count", 16'(word_count), 16'(m_count));
        check("timeout", 16'(timeout), 16'(m_tmo));
        if (m_full && exp_q.size() > 0) begin
            check("reg_hi", r_hi, exp_q[0]);
            check("reg_lo", r_lo, {exp_q[0][7:0], exp_q[0][15:8]});
        end
        @(posedge clk);
        if (clr) begin
            m_full = 0; m_have = 0; m_count = 8'h0; m_idle = 0; m_tmo = 0;
            exp_q.delete();
        end else begin
            m_tmo = 0;
            if (m_full) begin
                if (wr) begin
                    m_full = 0;
                    void'(exp_q.pop_front());
                    m_have = 0;
                    if (hs) begin m_have = 1; m_first = b; m_idle = 0; end
                end
            end else if (m_have == 0) begin
                if (hs) begin m_have = 1; m_first = b; m_idle = 0; end
            end else if (hs) begin
                m_full = 1;
                m_have = 0;
                exp_q.push_back({m_first, b});
                m_count = m_count + 8'd1;
            end else begin
`ifdef PARTIAL_TIMEOUT_EN
                m_idle++;
                if (m_idle == TMO) begin
                    m_have = 0;
                    m_tmo  = 1;
                end
`endif
            end
        end
        #1;
    endtask

    initial begin
        // Reset with byte_valid asserted
        cyc(1, 8'h99, 0, 1);
        cyc(1, 8'h98, 1, 1);
        check("reset_count", 16'(word_count), 16'h0);

        // Basic pair, then back-pressure
        cyc(1, 8'hAB, 0, 0);
        cyc(1, 8'hCD, 0, 0);
        check("basic_hi", r_hi, 16'hABCD);
        check("basic_lo", r_lo, 16'hCDAB);
        check("basic_count", 16'(word_count), 16'h1);
        for (int i = 0; i < 5; i++) cyc(1, 8'h11, 0, 0);

        // Streaming with zero bubbles
        cyc(1, 8'h11, 1, 0);
        cyc(1, 8'h22, 1, 0);
        check("stream_1122", r_hi, 16'h1122);
        cyc(1, 8'h33, 1, 0);
        cyc(1, 8'h44, 1, 0);
        check("stream_3344", r_hi, 16'h3344);
        cyc(1, 8'h55, 1, 0);
        cyc(1, 8'h66, 1, 0);
        check("stream_5566", r_hi, 16'h5566);
        check("stream_count", 16'(word_count), 16'h4);
        cyc(0, 8'h00, 1, 0);

        // Low-first instance ordering
        cyc(1, 8'h12, 0, 0);
        cyc(1, 8'h34, 0, 0);
        check("lo_first_word", r_lo, 16'h3412);
        cyc(0, 8'h00, 1, 0);

        // Reset mid-word
        cyc(1, 8'hEE, 0, 0);
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        check("midreset_word", r_hi, 16'h0102);
        check("midreset_count", 16'(word_count), 16'h1);
        cyc(0, 8'h00, 1, 0);

        // 256 back-to-back pairs wrap the word counter
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 510; i++) cyc(1, 8'($urandom), 1, 0);
        check("count_255", 16'(word_count), 16'd255);
        cyc(1, 8'($urandom), 1, 0);
        cyc(1, 8'($urandom), 1, 0);
        check("count_wrap", 16'(word_count), 16'd0);
        check("wrap_valid", 16'(word_valid), 16'h1);

        // Single byte then idle
        cyc(0, 8'h00, 1, 1);
        cyc(1, 8'h5A, 0, 0);
        for (int i = 0; i < TMO; i++) cyc(0, 8'h00, 0, 0);
`ifdef PARTIAL_TIMEOUT_EN
        check("timeout_pulse", 16'(timeout), 16'h1);
`else
        check("timeout_pulse", 16'(timeout), 16'h0);
`endif
        cyc(0, 8'h00, 0, 0);
        check("timeout_clear", 16'(timeout), 16'h0);
        cyc(1, 8'h77, 0, 0);
`ifdef PARTIAL_TIMEOUT_EN
        check("after_timeout_valid", 16'(word_valid), 16'h0);
`else
        check("after_timeout_valid", 16'(word_valid), 16'h1);
        check("held_word", r_hi, 16'h5A77);
`endif

        // Randomized traffic with occasional clear
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 59) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
